// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch-state encoding and instruction/address
// sizing used by the fetch unit and the control state machine.
package proc_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD_C = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: synchronous clear, load, or increment with natural
// wrap at 2^ADDR_WIDTH. Load takes priority over increment.
module pc_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);
  logic [ADDR_WIDTH-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, holds the
// fetched word on IR until the control FSM consumes it, then advances/redirects.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int                     ADDR_WIDTH  = ADDR_W,
  parameter int                     INSTR_WIDTH = INSTR_W,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = HALT_WORD_C
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_valid,
  output logic [INSTR_WIDTH-1:0] IR,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted
);
  fetch_state_e           state_d, state_q;
  logic [INSTR_WIDTH-1:0] ir_d, ir_q;
  logic                   data_accept;
  logic                   pc_load;

  // Only a strobe seen in WAIT counts; strays in any other state are dropped.
  assign data_accept = (state_q == ST_WAIT) && mem_valid;
  assign pc_load     = (state_q == ST_HOLD) && ir_ready && jump;

  pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .load_val (jump_addr),
    .inc      (data_accept),
    .pc       (pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          ir_d    = mem_rdata;
          state_d = (mem_rdata == HALT_WORD) ? ST_HALT : ST_HOLD;
        end
      end
      ST_HOLD: if (ir_ready) state_d = ST_REQ;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == ST_REQ);
    ir_valid = (state_q == ST_HOLD);
    halted   = (state_q == ST_HALT);
    mem_addr = mem_req ? pc : '0;
    IR       = ir_q;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, jump,
// wrap-to-halt, stray strobes, and reset during an outstanding read.
module tb_instr_fetch_unit;
  logic        clock = 1'b0;
  logic        reset, start, mem_req, mem_valid, ir_valid, ir_ready, jump, halted;
  logic [7:0]  mem_addr, jump_addr, pc;
  logic [15:0] mem_rdata, IR;
  int          checks = 0;
  int          passes = 0;

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock(clock), .reset(reset), .start(start), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .IR(IR), .ir_valid(ir_valid), .ir_ready(ir_ready), .jump(jump),
    .jump_addr(jump_addr), .pc(pc), .halted(halted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; jump = 1'b0; jump_addr = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else passes++;
    checks++; if (IR !== 16'h0000) $display("FAIL reset_ir got %h want 0000", IR); else passes++;
    checks++; if ({mem_req, ir_valid, halted} !== 3'b000) $display("FAIL reset_flags got %b want 000", {mem_req, ir_valid, halted}); else passes++;
    checks++; if (mem_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", mem_addr); else passes++;
  endtask

  task automatic test_first_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL first_req got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr); else passes++;
    tick();
    checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) $display("FAIL first_wait got req=%b ir_valid=%b want 0 0", mem_req, ir_valid); else passes++;
    mem_valid = 1'b1; mem_rdata = 16'd1;
    tick();
    mem_valid = 1'b0;
    checks++; if (IR !== 16'd1 || ir_valid !== 1'b1 || pc !== 8'd1) $display("FAIL first_data got IR=%h v=%b pc=%h want 0001 1 01", IR, ir_valid, pc); else passes++;
  endtask

  task automatic test_sequential();
    for (int i = 1; i < 4; i++) begin
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'(i)) $display("FAIL seq_req%0d got v=%b req=%b addr=%h want 0 1 %h", i, ir_valid, mem_req, mem_addr, 8'(i)); else passes++;
      tick();
      checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL seq_wait%0d got v=%b req=%b want 0 0", i, ir_valid, mem_req); else passes++;
      mem_valid = 1'b1; mem_rdata = 16'(i + 1);
      tick();
      mem_valid = 1'b0;
      checks++; if (IR !== 16'(i + 1) || ir_valid !== 1'b1) $display("FAIL seq_data%0d got IR=%h v=%b want %h 1", i, IR, ir_valid, 16'(i + 1)); else passes++;
    end
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_addr = 8'h40;
    tick();
    checks++; if (ir_valid !== 1'b1 || pc !== 8'h04) $display("FAIL jump_no_ready got v=%b pc=%h want 1 04", ir_valid, pc); else passes++;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0; jump = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) $display("FAIL jump_req got req=%b addr=%h want 1 40", mem_req, mem_addr); else passes++;
    tick();
    mem_valid = 1'b1; mem_rdata = 16'h0007;
    tick();
    mem_valid = 1'b0;
    checks++; if (pc !== 8'h41 || IR !== 16'h0007) $display("FAIL jump_data got pc=%h IR=%h want 41 0007", pc, IR); else passes++;
  endtask

  task automatic test_halt_wrap();
    ir_ready = 1'b1; jump = 1'b1; jump_addr = 8'hFF;
    tick();
    ir_ready = 1'b0; jump = 1'b0;
    checks++; if (mem_addr !== 8'hFF) $display("FAIL wrap_req got addr=%h want ff", mem_addr); else passes++;
    tick();
    mem_valid = 1'b1; mem_rdata = 16'd5;
    tick();
    mem_valid = 1'b0;
    checks++; if (pc !== 8'h00 || IR !== 16'd5 || ir_valid !== 1'b1) $display("FAIL wrap_pc got pc=%h IR=%h v=%b want 00 0005 1", pc, IR, ir_valid); else passes++;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL halt_req got req=%b addr=%h want 1 00", mem_req, mem_addr); else passes++;
    tick();
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_valid = 1'b0;
    checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || IR !== 16'hFFFF || pc !== 8'h01) $display("FAIL halt_state got h=%b v=%b IR=%h pc=%h want 1 0 ffff 01", halted, ir_valid, IR, pc); else passes++;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      ir_ready = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0 || halted !== 1'b1) $display("FAIL halt_stick%0d got req=%b h=%b want 0 1", i, mem_req, halted); else passes++;
    end
    start = 1'b0; ir_ready = 1'b0;
  endtask

  task automatic test_stray_strobes();
    reset = 1'b1; start = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0 || halted !== 1'b0 || IR !== 16'h0000) $display("FAIL reset_wins got req=%b h=%b IR=%h want 0 0 0000", mem_req, halted, IR); else passes++;
    reset = 1'b0;
    tick();
    start = 1'b0;
    mem_valid = 1'b1; mem_rdata = 16'h0BAD;
    tick();
    mem_valid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || IR !== 16'h0000 || pc !== 8'h00) $display("FAIL stray_req got v=%b IR=%h pc=%h want 0 0000 00", ir_valid, IR, pc); else passes++;
    tick(); tick();
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL lat_wait got v=%b req=%b want 0 0", ir_valid, mem_req); else passes++;
    mem_valid = 1'b1; mem_rdata = 16'h00AA;
    tick();
    checks++; if (IR !== 16'h00AA || ir_valid !== 1'b1 || pc !== 8'h01) $display("FAIL lat_data got IR=%h v=%b pc=%h want 00aa 1 01", IR, ir_valid, pc); else passes++;
    mem_rdata = 16'h5555;
    tick();
    mem_valid = 1'b0;
    checks++; if (IR !== 16'h00AA || ir_valid !== 1'b1 || pc !== 8'h01) $display("FAIL stray_hold got IR=%h v=%b pc=%h want 00aa 1 01", IR, ir_valid, pc); else passes++;
  endtask

  task automatic test_reset_in_wait();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) $display("FAIL rw_req got req=%b addr=%h want 1 01", mem_req, mem_addr); else passes++;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_valid = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_valid = 1'b0;
    checks++; if (IR !== 16'h0000 || pc !== 8'h00 || mem_addr !== 8'h00) $display("FAIL rw_data got IR=%h pc=%h addr=%h want 0000 00 00", IR, pc, mem_addr); else passes++;
    checks++; if ({mem_req, ir_valid, halted} !== 3'b000) $display("FAIL rw_flags got %b want 000", {mem_req, ir_valid, halted}); else passes++;
    tick();
    checks++; if (mem_req !== 1'b0 || IR !== 16'h0000) $display("FAIL rw_idle got req=%b IR=%h want 0 0000", mem_req, IR); else passes++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_jump();
    test_halt_wrap();
    test_stray_strobes();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
